code_lock_ctrl: RTL
===================

Name: code_lock_ctrl

Overview:
- Sequential combination-lock controller for the Basys3 board.
- Collects a code one digit per debounced button press and compares each digit against a stored code register using a per-digit equality compare.
- Sequences accept/reject, counts failed attempts and enforces a timed lockout.
- Supports reprogramming the code while unlocked.
- Sits between the switch/button conditioning logic and the LED/7-segment status drivers.

Parameters:
- DIGIT_BITS, 4, width of one code digit (switch group).
- CODE_LEN, 4, digits per code.
- DEFAULT_CODE, 16'h1234, code loaded at reset. Width DIGIT_BITS*CODE_LEN; first-entered digit is the MS digit.
- MAX_TRIES, 3, consecutive failed attempts that trigger lockout (≥1).
- LOCKOUT_CYCLES, 100_000_000, lockout duration in clk cycles (1 s at 100 MHz).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous active-high reset.
- digit_in  input  DIGIT_BITS  current digit value from switches.
- enter  input  1  one-cycle pulse (already debounced/edge-detected): accept digit_in.
- clear  input  1  one-cycle pulse: abort current entry/programming.
- lock  input  1  one-cycle pulse: relock when open.
- prog  input  1  level: while open, the next enter starts programming.
- unlocked  output  1  high in OPEN.
- bad_code  output  1  one-cycle pulse on a rejected code.
- locked_out  output  1  high in LOCKOUT.
- programming  output  1  high in PROGRAM.
- digits_entered  output  $clog2(CODE_LEN+1)  digits accepted in the current entry/program sequence.
- fail_count  output  $clog2(MAX_TRIES+1)  consecutive failures.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; rst is sampled on the rising clk edge and overrides everything, including mid-sequence and mid-lockout.
- Reset values: state=LOCKED, code register=DEFAULT_CODE, all outputs 0, mismatch flag=0, lockout counter=0.
- Digit indexing: digit k (0-based entry order) compares against code[(CODE_LEN-1-k)*DIGIT_BITS +: DIGIT_BITS]. The mismatch flag is a sticky OR of (digit_in != expected) over all digits of the attempt.
- LOCKED:
  - enter → compare digit 0, set mismatch, digits_entered=1, go to ENTRY.
  - If CODE_LEN==1, go straight to CHECK.
  - lock and prog are ignored.
- ENTRY:
  - Each enter compares the next digit and increments digits_entered.
  - On the enter that makes digits_entered==CODE_LEN, go to CHECK.
  - clear → LOCKED, digits_entered=0, mismatch=0, fail_count unchanged.
  - clear and enter in the same cycle: clear wins and the digit is discarded.
- CHECK (exactly 1 cycle; enter and clear ignored). Clear digits_entered and mismatch, then:
  - Match → OPEN, fail_count=0.
  - Mismatch → bad_code=1 for this cycle's registered output (visible the next cycle) and fail_count+1.
    - If the new count == MAX_TRIES → LOCKOUT, counter loaded to LOCKOUT_CYCLES-1.
    - Otherwise → LOCKED.
- OPEN: unlocked=1.
  - lock → LOCKED.
  - enter with prog=1 → PROGRAM; that digit is stored as new digit 0 in a shadow register, digits_entered=1.
  - enter with prog=0 is ignored.
  - lock and enter in the same cycle: lock wins.
- PROGRAM: programming=1, unlocked stays 1.
  - Each enter stores the next digit into the shadow register.
  - On the CODE_LEN-th digit, copy the shadow to the code register in the same edge → OPEN, digits_entered=0.
  - clear → OPEN, code register unchanged.
  - A partial program never alters the code.
- LOCKOUT: locked_out=1; enter, clear, lock and prog are all ignored.
  - Counter decrements once per cycle.
  - At 0 → LOCKED, fail_count=0.
  - Total LOCKOUT_CYCLES cycles in the state.
- Outputs: all registered; no combinational input-to-output paths.

Decomposition:
- Shared package code_lock_pkg:
  - state enum: LOCKED, ENTRY, CHECK, OPEN, PROGRAM, LOCKOUT (3-bit encoding).
  - Width localparams derived via $clog2.
- One sub-module: lock_timer, a loadable down-counter with load, load_value, en and zero outputs, width $clog2(LOCKOUT_CYCLES).
- Digit compare stays inline in the FSM.

Test Plan (DEFAULT_CODE=16'h1234, MAX_TRIES=3, LOCKOUT_CYCLES=20):
- Correct code: enter 1,2,3,4 → CHECK for 1 cycle, then unlocked=1, bad_code never pulses, fail_count=0.
- Wrong code: enter 1,2,3,5 → one bad_code pulse, fail_count=1, state LOCKED; a following correct 1,2,3,4 → unlocked=1, fail_count=0.
- Lockout: three wrong codes → fail_count=3, locked_out=1 for exactly 20 cycles, and enter pulses during that window are ignored. Afterwards locked_out=0 and fail_count=0, and 1,2,3,4 unlocks.
- Clear priority: enter 1,2, then clear+enter on the same cycle → digits_entered=0, LOCKED, fail_count unchanged; 1,2,3,4 then unlocks.
- Reprogram: unlock, set prog=1, enter 9,8,7,6, pulse lock → old code 1,2,3,4 gives bad_code; 9,8,7,6 gives unlocked=1. Repeat with clear after 2 digits → code still 9876.
- Reset mid-lockout and mid-program: rst pulse → all outputs 0, state LOCKED, and code reverts to 1234.

Source files
------------

// File: rtl/code_lock_pkg.sv
// code_lock_pkg: shared FSM state encoding and default sizing for the code lock
package code_lock_pkg;
  typedef enum logic [2:0] {LOCKED, ENTRY, CHECK, OPEN, PROGRAM, LOCKOUT} state_t;
  localparam int DEF_DIGIT_BITS = 4;
  localparam int DEF_CODE_LEN = 4;
  localparam int DEF_MAX_TRIES = 3;
  localparam int DEF_LOCKOUT_CYCLES = 100_000_000;
  localparam int DEF_DE_W = $clog2(DEF_CODE_LEN + 1);
  localparam int DEF_FC_W = $clog2(DEF_MAX_TRIES + 1);
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter that stops at zero
module lock_timer #(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_value;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: digit-at-a-time combination lock with retry lockout and reprogramming
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int DIGIT_BITS = DEF_DIGIT_BITS,
  parameter int CODE_LEN = DEF_CODE_LEN,
  parameter logic [DIGIT_BITS*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234,
  parameter int MAX_TRIES = DEF_MAX_TRIES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DIGIT_BITS-1:0]           digit_in,
  input  logic                            enter,
  input  logic                            clear,
  input  logic                            lock,
  input  logic                            prog,
  output logic                            unlocked,
  output logic                            bad_code,
  output logic                            locked_out,
  output logic                            programming,
  output logic [$clog2(CODE_LEN+1)-1:0]   digits_entered,
  output logic [$clog2(MAX_TRIES+1)-1:0]  fail_count
);
  localparam int CW = DIGIT_BITS * CODE_LEN;
  localparam int DEW = $clog2(CODE_LEN + 1);
  localparam int FCW = $clog2(MAX_TRIES + 1);
  localparam int TW = cnt_w(LOCKOUT_CYCLES);
  state_t state_r, state_n;
  logic [DEW-1:0] de_r, de_n;
  logic [FCW-1:0] fail_r, fail_n, fail_inc;
  logic [CW-1:0] code_r, code_n, shadow_r, shadow_n;
  logic [DIGIT_BITS-1:0] exp_d;
  logic mm_r, mm_n, bad_r, bad_n, t_load, t_zero, ne, last;
  int idx;
  lock_timer #(.W(TW)) u_timer (
    .clk(clk), .rst(rst), .load(t_load), .load_value(TW'(LOCKOUT_CYCLES - 1)),
    .en(state_r == LOCKOUT), .zero(t_zero)
  );
  // idx addresses the digit slot for the next accepted digit, MS digit first
  always_comb begin
    state_n = state_r;
    de_n = de_r;
    mm_n = mm_r;
    fail_n = fail_r;
    code_n = code_r;
    shadow_n = shadow_r;
    bad_n = 1'b0;
    t_load = 1'b0;
    idx = (CODE_LEN - 1 - int'(de_r)) * DIGIT_BITS;
    exp_d = code_r[idx +: DIGIT_BITS];
    ne = digit_in != exp_d;
    last = de_r == DEW'(CODE_LEN - 1);
    fail_inc = fail_r + 1'b1;
    case (state_r)
      LOCKED: if (enter) begin
        de_n = de_r + 1'b1;
        mm_n = ne;
        state_n = last ? CHECK : ENTRY;
      end
      ENTRY: if (clear) begin
        state_n = LOCKED;
        de_n = '0;
        mm_n = 1'b0;
      end else if (enter) begin
        de_n = de_r + 1'b1;
        mm_n = mm_r | ne;
        state_n = last ? CHECK : ENTRY;
      end
      CHECK: begin
        de_n = '0;
        mm_n = 1'b0;
        if (!mm_r) begin
          state_n = OPEN;
          fail_n = '0;
        end else begin
          bad_n = 1'b1;
          fail_n = fail_inc;
          t_load = fail_inc == FCW'(MAX_TRIES);
          state_n = t_load ? LOCKOUT : LOCKED;
        end
      end
      OPEN: if (lock) state_n = LOCKED;
      else if (enter && prog) begin
        shadow_n[idx +: DIGIT_BITS] = digit_in;
        code_n = last ? shadow_n : code_r;
        de_n = last ? '0 : DEW'(1);
        state_n = last ? OPEN : PROGRAM;
      end
      PROGRAM: if (clear) begin
        state_n = OPEN;
        de_n = '0;
      end else if (enter) begin
        shadow_n[idx +: DIGIT_BITS] = digit_in;
        code_n = last ? shadow_n : code_r;
        de_n = last ? '0 : de_r + 1'b1;
        state_n = last ? OPEN : PROGRAM;
      end
      LOCKOUT: if (t_zero) begin
        state_n = LOCKED;
        fail_n = '0;
      end
      default: state_n = LOCKED;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_r <= LOCKED;
      de_r <= '0;
      mm_r <= 1'b0;
      fail_r <= '0;
      code_r <= DEFAULT_CODE;
      shadow_r <= '0;
      bad_r <= 1'b0;
    end else begin
      state_r <= state_n;
      de_r <= de_n;
      mm_r <= mm_n;
      fail_r <= fail_n;
      code_r <= code_n;
      shadow_r <= shadow_n;
      bad_r <= bad_n;
    end
  assign unlocked = state_r == OPEN || state_r == PROGRAM;
  assign programming = state_r == PROGRAM;
  assign locked_out = state_r == LOCKOUT;
  assign bad_code = bad_r;
  assign digits_entered = de_r;
  assign fail_count = fail_r;
endmodule
